// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: shares the single-port tile RAM between the board-init
// engine (absolute priority), the game logic and the VGA tile renderer.
// Game and video are round-robin arbitrated; read data returns one cycle
// after the grant with a per-client valid strobe.
module board_ram_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_hold,
  input  logic              init_req,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  output logic              init_gnt,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic              game_rvalid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // 0 = game was served last, 1 = video was served last
  logic r_rr_last;
  logic r_game_rvalid;
  logic r_vid_rvalid;

  logic w_init_gnt;
  logic w_game_gnt;
  logic w_vid_gnt;

  // Grant selection: init first, then hold blocks game/video, then round-robin
  always_comb begin
    w_init_gnt = 1'b0;
    w_game_gnt = 1'b0;
    w_vid_gnt  = 1'b0;
    if (!reset) begin
      if (init_req) begin
        w_init_gnt = 1'b1;
      end else if (!init_hold) begin
        if (game_req && vid_req) begin
          w_game_gnt = r_rr_last;
          w_vid_gnt  = !r_rr_last;
        end else begin
          w_game_gnt = game_req;
          w_vid_gnt  = vid_req;
        end
      end
    end
  end

  // RAM port mux driven from whichever client holds the grant
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (w_init_gnt) begin
      ram_addr  = init_addr;
      ram_we    = init_we;
      ram_wdata = init_wdata;
    end else if (w_game_gnt) begin
      ram_addr  = game_addr;
      ram_we    = game_we;
      ram_wdata = game_wdata;
    end else if (w_vid_gnt) begin
      ram_addr  = vid_addr;
    end
  end

  // Round-robin pointer and read-valid pipeline; init grants leave rr_last alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_last     <= 1'b1;
      r_game_rvalid <= 1'b0;
      r_vid_rvalid  <= 1'b0;
    end else begin
      if (w_game_gnt) begin
        r_rr_last <= 1'b0;
      end else if (w_vid_gnt) begin
        r_rr_last <= 1'b1;
      end
      r_game_rvalid <= w_game_gnt && !game_we;
      r_vid_rvalid  <= w_vid_gnt;
    end
  end

  assign init_gnt = w_init_gnt;
  assign game_gnt = w_game_gnt;
  assign vid_gnt  = w_vid_gnt;
  // Masked by reset so a strobe already in flight is dropped in the reset cycle itself
  assign game_rvalid = r_game_rvalid && !reset;
  assign vid_rvalid  = r_vid_rvalid && !reset;
  assign rdata       = ram_rdata;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Testbench for board_ram_arbiter: directed scenarios followed by randomized
// client traffic, all checked against a behavioural model of the arbiter
// with a shadow copy of the board RAM.
module tb_board_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_hold, init_req, init_we, init_gnt;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_wdata;
  logic          game_req, game_we, game_gnt, game_rvalid;
  logic [AW-1:0] game_addr;
  logic [DW-1:0] game_wdata;
  logic          vid_req, vid_gnt, vid_rvalid;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  board_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .init_hold(init_hold), .init_req(init_req), .init_we(init_we),
    .init_addr(init_addr), .init_wdata(init_wdata), .init_gnt(init_gnt),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
    .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rvalid(game_rvalid),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Board RAM: single port, one-cycle synchronous read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            last_served = 1;   // 0 = game, 1 = video
  logic          pend_g = 1'b0, pend_v = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic          m_eg = 1'b0, m_ev = 1'b0;
  // Observed outputs of the most recent cycle
  logic          o_ig, o_gg, o_vg, o_grv, o_vrv;
  logic [DW-1:0] o_rd;

  // One clock cycle: inputs already driven; check at negedge, advance model
  task automatic one_cycle();
    logic ei, eg, ev, ewe, xg, xv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    @(negedge clk);
    ei = 1'b0; eg = 1'b0; ev = 1'b0;
    if (!reset) begin
      if (init_req) ei = 1'b1;
      else if (!init_hold) begin
        if (game_req && vid_req) begin
          if (last_served == 1) eg = 1'b1; else ev = 1'b1;
        end else begin
          eg = game_req;
          ev = vid_req;
        end
      end
    end
    ea = '0; ewe = 1'b0; ewd = '0;
    if (ei) begin ea = init_addr; ewe = init_we; ewd = init_wdata; end
    else if (eg) begin ea = game_addr; ewe = game_we; ewd = game_wdata; end
    else if (ev) ea = vid_addr;
    xg = pend_g && !reset;
    xv = pend_v && !reset;
    check_eq("gnt", 32'({init_gnt, game_gnt, vid_gnt}), 32'({ei, eg, ev}));
    check_eq("ram_we", 32'(ram_we), 32'(ewe));
    check_eq("ram_addr", 32'(ram_addr), 32'(ea));
    check_eq("ram_wdata", 32'(ram_wdata), 32'(ewd));
    check_eq("rvalid", 32'({game_rvalid, vid_rvalid}), 32'({xg, xv}));
    if (xg || xv) check_eq("rdata", 32'(rdata), 32'(pend_data));
    o_ig = init_gnt; o_gg = game_gnt; o_vg = vid_gnt;
    o_grv = game_rvalid; o_vrv = vid_rvalid; o_rd = rdata;
    pend_g = eg && !game_we;
    pend_v = ev;
    if (eg && !game_we) pend_data = shadow[game_addr];
    else if (ev) pend_data = shadow[vid_addr];
    if (ewe) shadow[ea] = ewd;
    if (reset) last_served = 1;
    else if (eg) last_served = 0;
    else if (ev) last_served = 1;
    m_eg = eg; m_ev = ev;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gc, vc, both;
    reset = 1'b1; init_hold = 1'b0; init_req = 1'b0; init_we = 1'b0;
    init_addr = '0; init_wdata = '0;
    game_req = 1'b0; game_we = 1'b0; game_addr = '0; game_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;

    // Reset: everything quiet
    repeat (3) one_cycle();
    check_eq("rst_gnt", 32'({o_ig, o_gg, o_vg}), 32'd0);
    check_eq("rst_rvalid", 32'({o_grv, o_vrv}), 32'd0);

    // Fill addresses 0..63 through the init engine
    reset = 1'b0; init_hold = 1'b1; init_req = 1'b1; init_we = 1'b1;
    for (int a = 0; a < 64; a++) begin
      init_addr = AW'(a);
      init_wdata = DW'((a + 5) & 7);
      one_cycle();
      check_eq("fill_gnt", 32'(o_ig), 32'd1);
    end
    init_req = 1'b0; init_hold = 1'b0; init_we = 1'b0;

    // First tie after reset goes to game; read latency one cycle
    game_req = 1'b1; game_we = 1'b0; game_addr = 11'd5;
    vid_req = 1'b1; vid_addr = 11'd7;
    one_cycle();
    check_eq("tie0_game", 32'({o_gg, o_vg}), 32'b10);
    game_req = 1'b0;
    one_cycle();
    check_eq("tie1_vid", 32'(o_vg), 32'd1);
    check_eq("game_rv", 32'(o_grv), 32'd1);
    check_eq("game_rd5", 32'(o_rd), 32'd2);
    vid_req = 1'b0;
    one_cycle();
    check_eq("vid_rv", 32'(o_vrv), 32'd1);
    check_eq("vid_rd7", 32'(o_rd), 32'd4);

    // Continuous contention: strict alternation
    game_req = 1'b1; game_addr = 11'd20; vid_req = 1'b1; vid_addr = 11'd21;
    gc = 0; vc = 0; both = 0;
    repeat (8) begin
      one_cycle();
      gc += int'(o_gg); vc += int'(o_vg);
      if (o_gg && o_vg) both++;
    end
    check_eq("alt_game", 32'(gc), 32'd4);
    check_eq("alt_vid", 32'(vc), 32'd4);
    check_eq("alt_both", 32'(both), 32'd0);
    game_req = 1'b0; vid_req = 1'b0;
    one_cycle();

    // init_hold blocks game while init writes 0..3 with 1
    init_hold = 1'b1; init_we = 1'b1; init_wdata = 3'd1;
    game_req = 1'b1; game_we = 1'b0; game_addr = 11'd30;
    gc = 0;
    for (int i = 0; i < 8; i++) begin
      init_req = (i % 2 == 0);
      init_addr = AW'(i / 2);
      one_cycle();
      gc += int'(o_gg);
    end
    check_eq("hold_game", 32'(gc), 32'd0);
    init_hold = 1'b0; init_req = 1'b0;
    one_cycle();
    check_eq("unhold_game", 32'(o_gg), 32'd1);
    game_req = 1'b0;
    one_cycle();
    for (int a = 0; a < 4; a++) begin
      game_req = 1'b1; game_addr = AW'(a);
      one_cycle();
      game_req = 1'b0;
      one_cycle();
      check_eq("init_rv", 32'(o_grv), 32'd1);
      check_eq("init_rd", 32'(o_rd), 32'd1);
    end

    // Write then immediate read of the same address
    game_req = 1'b1; game_we = 1'b1; game_addr = 11'd10; game_wdata = 3'd3;
    one_cycle();
    game_we = 1'b0;
    one_cycle();
    game_req = 1'b0;
    one_cycle();
    check_eq("wr_rd_rv", 32'(o_grv), 32'd1);
    check_eq("wr_rd_data", 32'(o_rd), 32'd3);

    // Reset right after a video read grant discards its strobe
    vid_req = 1'b1; vid_addr = 11'd9;
    one_cycle();
    check_eq("vid_pre_rst", 32'(o_vg), 32'd1);
    vid_req = 1'b0; reset = 1'b1; game_req = 1'b1; game_addr = 11'd2;
    one_cycle();
    check_eq("rst_vrv", 32'(o_vrv), 32'd0);
    check_eq("rst_mid_gnt", 32'({o_ig, o_gg, o_vg}), 32'd0);
    reset = 1'b0; vid_req = 1'b1;
    one_cycle();
    check_eq("post_rst_vrv", 32'(o_vrv), 32'd0);
    check_eq("post_rst_tie", 32'({o_gg, o_vg}), 32'b10);
    game_req = 1'b0;
    one_cycle();
    vid_req = 1'b0;
    one_cycle();

    // Init preempts a tie and leaves the round-robin order alone (video served last)
    init_req = 1'b1; init_we = 1'b0; init_addr = 11'd0;
    game_req = 1'b1; vid_req = 1'b1;
    one_cycle();
    check_eq("init_pri", 32'({o_ig, o_gg, o_vg}), 32'b100);
    init_req = 1'b0;
    one_cycle();
    check_eq("init_rr", 32'({o_gg, o_vg}), 32'b10);
    game_req = 1'b0;
    one_cycle();
    vid_req = 1'b0;
    one_cycle();

    // Randomized traffic obeying the req/gnt handshake
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) init_hold = ~init_hold;
      init_req = init_hold ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      init_we = 1'($urandom_range(0, 1));
      init_addr = AW'($urandom_range(0, 63));
      init_wdata = DW'($urandom_range(0, 7));
      if (m_eg || !game_req) begin
        if ($urandom_range(0, 3) != 0) begin
          if (!(m_eg && $urandom_range(0, 2) == 0)) game_addr = AW'($urandom_range(0, 63));
          game_we = m_eg && game_we ? 1'b0 : 1'($urandom_range(0, 1));
          game_wdata = DW'($urandom_range(0, 7));
          game_req = 1'b1;
        end else begin
          game_req = 1'b0;
        end
      end
      if (m_ev || !vid_req) begin
        vid_req = ($urandom_range(0, 3) != 0);
        vid_addr = AW'($urandom_range(0, 63));
      end
      one_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
- Shares the single-port board RAM (one tile code per cell) between three clients: the board-initialisation engine, the game logic (Pac-Man/ghost moves, pellet erase), and the VGA tile renderer.
- The init engine has absolute priority. While the init hold signal is high, it owns the RAM exclusively.
- Otherwise, game and video requests are round-robin arbitrated, one access per cycle.
- Read data is returned one cycle after the grant, with a per-client valid strobe.

Parameters:
ADDR_W, 11, board RAM address width (40x30 = 1200 tiles)
DATA_W, 3, tile code width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
init_hold  in  1  init engine busy; blocks game/video grants
init_req  in  1  init access request
init_we  in  1  init write enable
init_addr  in  ADDR_W  init address
init_wdata  in  DATA_W  init write data
init_gnt  out  1  init access accepted this cycle
game_req  in  1  game access request
game_we  in  1  game write enable
game_addr  in  ADDR_W  game address
game_wdata  in  DATA_W  game write data
game_gnt  out  1  game access accepted this cycle
game_rvalid  out  1  rdata valid for game
vid_req  in  1  video read request (read-only client)
vid_addr  in  ADDR_W  video address
vid_gnt  out  1  video access accepted this cycle
vid_rvalid  out  1  rdata valid for video
rdata  out  DATA_W  shared read-data bus (ram_rdata passthrough)
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency

Behaviour:
- Handshake
  - A client holds req, addr, we and wdata stable until it sees gnt high.
  - The access is complete in the gnt cycle, so the client may change addr or drop req in the next cycle.
  - At most one gnt is high per cycle.
- Grant is combinational, in cycle t:
  1. If init_req is high, init_gnt = 1. This holds regardless of init_hold.
  2. Else if init_hold is high, no grant is issued; ram_we = 0.
  3. Else if exactly one of game_req / vid_req is high, that client is granted.
  4. Else if both are high, the client not flagged by rr_last is granted.
- rr_last register
  - 1 bit: 0 = game last, 1 = video last.
  - Updates at the clock edge only on a game or video grant.
  - Unchanged on init grants and idle cycles.
- RAM drive, combinational from the granted client
  - ram_addr, ram_we and ram_wdata follow the granted client; the video client always has we = 0.
  - With no grant: ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Read return
  - game_rvalid and vid_rvalid are registered.
  - Each is high in cycle t+1 if and only if that client received a read grant (we = 0) in cycle t.
  - rdata = ram_rdata continuously. Clients sample it only on their rvalid.
  - init reads are permitted but return no valid strobe; the init engine times the data itself.
- Write latency: a write is visible to a read granted in cycle t+1 or later. Back-to-back write then read to the same address returns the new value.
- Throughput: one access per cycle. With continuous game and video requests, grants strictly alternate.
- Reset, while reset is high:
  - All gnt outputs = 0 and ram_we = 0; ram outputs = 0.
  - rvalids are cleared at the edge.
  - rr_last = 1, so game wins the first tie.
  - Reset mid-transaction discards any pending rvalid. The outstanding read is not re-issued; clients must re-request.
- init_hold rising mid-stream: the game/video grant stops in that same cycle. A request ungranted that cycle stays pending and is served after init_hold falls, in round-robin order.
- init_hold falling: game/video are eligible in the same cycle.

Test Plan:
- Reset released, game_req=1 read addr 5 (RAM[5]=3'd2), vid_req=1 addr 7 in the same cycle -> game_gnt cycle 0; game_rvalid cycle 1 with rdata=2; vid_gnt cycle 1; vid_rvalid cycle 2.
- game and video both requesting continuously for 8 cycles -> grants alternate game, vid, game, ...; 4 each; never both high.
- init_hold=1, init_req toggling every other cycle writing addr 0..3 with data 1, game_req=1 throughout -> game_gnt=0 for the whole hold; RAM[0..3]=1; game_gnt=1 in the first cycle after init_hold falls.
- game write addr 10 data 3 in cycle t, game read addr 10 in cycle t+1 -> game_rvalid at t+2 with rdata=3.
- vid read granted in cycle t, reset asserted in t+1 -> vid_rvalid=0 in t+1 and t+2; all gnt=0 during reset; first tie after reset goes to game.
- init_req=1 with init_hold=0 while game_req and vid_req are high -> init_gnt=1 and others 0; rr_last is unchanged, so the next tie follows the prior round-robin order.
